// File: rtl/br_pkg.sv
// br_pkg: default widths and side-band record layout for the branch resolve unit
package br_pkg;

    localparam int DEF_PC_W  = 32;
    localparam int DEF_CNT_W = 32;

    typedef struct packed {
        logic                valid;
        logic                pred;
        logic [DEF_PC_W-1:0] pc_plus4;
        logic [DEF_PC_W-1:0] pred_target;
    } sb_t;

endpackage

// File: rtl/br_ifid_sideband.sv
// br_ifid_sideband: IF/ID register carrying the fetch-time prediction into ID
module br_ifid_sideband
    import br_pkg::*;
#(
    parameter int PC_W = DEF_PC_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            if_valid,
    input  logic            if_br_pre,
    input  logic [PC_W-1:0] if_pc_plus4,
    input  logic [PC_W-1:0] if_pred_target,
    output logic            sb_valid,
    output logic            sb_pred,
    output logic [PC_W-1:0] sb_pc_plus4,
    output logic [PC_W-1:0] sb_pred_target
);

    // stall holds everything (and wins over flush); flush only kills the valid/pred bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid       <= 1'b0;
            sb_pred        <= 1'b0;
            sb_pc_plus4    <= '0;
            sb_pred_target <= '0;
        end else if (!stall) begin
            sb_valid       <= if_valid & ~flush;
            sb_pred        <= if_br_pre & ~flush;
            sb_pc_plus4    <= if_pc_plus4;
            sb_pred_target <= if_pred_target;
        end
    end

endmodule

// File: rtl/br_resolve_unit.sv
// br_resolve_unit: compares fetch prediction with ID outcome, drives redirect and predictor feedback
// Optional saturating statistics counters are built when BR_STATS_EN is defined.
module br_resolve_unit
    import br_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             if_valid,
    input  logic [PC_W-1:0]  if_pc_plus4,
    input  logic             if_br_pre,
    input  logic [PC_W-1:0]  if_pred_target,
    input  logic             id_is_branch,
    input  logic             id_br_taken,
    input  logic [PC_W-1:0]  id_br_target,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush_ifid,
    output logic             PreRight,
    output logic             PreWrong,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] miss_count
);

    logic            sb_valid;
    logic            sb_pred;
    logic [PC_W-1:0] sb_pc_plus4;
    logic [PC_W-1:0] sb_pred_target;
    logic            resolve;
    logic            wrong;

    br_ifid_sideband #(.PC_W(PC_W)) u_sideband (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush_ifid),
        .if_valid       (if_valid),
        .if_br_pre      (if_br_pre),
        .if_pc_plus4    (if_pc_plus4),
        .if_pred_target (if_pred_target),
        .sb_valid       (sb_valid),
        .sb_pred        (sb_pred),
        .sb_pc_plus4    (sb_pc_plus4),
        .sb_pred_target (sb_pred_target)
    );

    // a taken prediction to the wrong target is a miss even when the direction matched
    always_comb begin
        resolve        = sb_valid & id_is_branch & ~stall;
        wrong          = resolve & ((sb_pred != id_br_taken) |
                                    (sb_pred & id_br_taken & (sb_pred_target != id_br_target)));
        redirect_valid = wrong;
        redirect_pc    = wrong ? (id_br_taken ? id_br_target : sb_pc_plus4) : '0;
        flush_ifid     = wrong;
    end

    // one-cycle right/wrong feedback to the predictor FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PreRight <= 1'b0;
            PreWrong <= 1'b0;
        end else begin
            PreRight <= resolve & ~wrong;
            PreWrong <= wrong;
        end
    end

`ifdef BR_STATS_EN
    // saturating resolution and misprediction counters, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count   <= '0;
            miss_count <= '0;
        end else begin
            if (resolve && br_count != '1)
                br_count <= br_count + 1'b1;
            if (wrong && miss_count != '1)
                miss_count <= miss_count + 1'b1;
        end
    end
`else
    assign br_count   = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_br_resolve_unit.sv
// tb_br_resolve_unit: scoreboard bench for br_resolve_unit (narrow counters to reach saturation)
module tb_br_resolve_unit;

    localparam int PW = 32;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic          if_valid = 1'b0;
    logic [PW-1:0] if_pc_plus4 = '0;
    logic          if_br_pre = 1'b0;
    logic [PW-1:0] if_pred_target = '0;
    logic          id_is_branch = 1'b0;
    logic          id_br_taken = 1'b0;
    logic [PW-1:0] id_br_target = '0;
    logic          redirect_valid;
    logic [PW-1:0] redirect_pc;
    logic          flush_ifid;
    logic          PreRight;
    logic          PreWrong;
    logic [CW-1:0] br_count;
    logic [CW-1:0] miss_count;

    int checks = 0;
    int passes = 0;

    logic [1:0]    pq[$];
    logic [PW-1:0] rq[$];

    br_resolve_unit #(.PC_W(PW), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_pc_plus4    (if_pc_plus4),
        .if_br_pre      (if_br_pre),
        .if_pred_target (if_pred_target),
        .id_is_branch   (id_is_branch),
        .id_br_taken    (id_br_taken),
        .id_br_target   (id_br_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_ifid     (flush_ifid),
        .PreRight       (PreRight),
        .PreWrong       (PreWrong),
        .br_count       (br_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // one cycle of stimulus; pulse = {PreRight, PreWrong} expected one cycle later
    task automatic step(input logic ifv, input logic pre, input logic [PW-1:0] pc4,
                        input logic [PW-1:0] ptgt, input logic isb, input logic tk,
                        input logic [PW-1:0] tgt, input logic stl, input logic [1:0] pulse,
                        input logic rv, input logic [PW-1:0] rpc);
        @(posedge clk);
        #1;
        if_valid       = ifv;
        if_br_pre      = pre;
        if_pc_plus4    = pc4;
        if_pred_target = ptgt;
        id_is_branch   = isb;
        id_br_taken    = tk;
        id_br_target   = tgt;
        stall          = stl;
        if (pulse != 2'b00) pq.push_back(pulse);
        if (rv) rq.push_back(rpc);
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, 0, '0, 0, 2'b00, 0, '0);
    endtask

    // monitor: every redirect or feedback pulse must match the head of its queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (redirect_valid) begin
                if (rq.size() == 0)
                    chk("unexpected_redirect", redirect_valid, 0);
                else begin
                    chk("redirect_pc", redirect_pc, rq.pop_front());
                    chk("flush_with_redirect", flush_ifid, 1);
                end
            end else if (flush_ifid)
                chk("spurious_flush", flush_ifid, 0);
            if (PreRight || PreWrong) begin
                if (pq.size() == 0)
                    chk("unexpected_pulse", {PreRight, PreWrong}, 0);
                else
                    chk("pulse", {PreRight, PreWrong}, pq.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_pre_right", PreRight, 0);
        chk("rst_pre_wrong", PreWrong, 0);
        chk("rst_br_count", br_count, 0);
        rst_n = 1'b1;
        idle();
        // mid-run reset while a misprediction is being redirected
        step(1, 0, 32'h104, 32'h0, 0, 0, 32'h0, 0, 2'b00, 0, '0);
        step(0, 0, 32'h0, 32'h0, 1, 1, 32'h300, 0, 2'b01, 1, 32'h300);
        #6;
        rst_n = 1'b0;
        #1;
        chk("async_rst_redirect", redirect_valid, 0);
        chk("async_rst_flush", flush_ifid, 0);
        chk("async_rst_pre_right", PreRight, 0);
        chk("async_rst_pre_wrong", PreWrong, 0);
        pq.delete();
        rq.delete();
        @(posedge clk);
        #1;
        chk("rst_no_pending_pulse", PreWrong, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_sb_invalid", redirect_valid, 0);
        idle();
        // back-to-back correct not-taken branches
        step(1, 0, 32'h104, 32'h0, 0, 0, 32'h0, 0, 2'b00, 0, '0);
        step(1, 0, 32'h108, 32'h0, 1, 0, 32'h400, 0, 2'b10, 0, '0);
        step(0, 0, 32'h0, 32'h0, 1, 0, 32'h400, 0, 2'b10, 0, '0);
        // predicted taken, actually not taken; following slot must be flushed
        step(1, 1, 32'h104, 32'h200, 0, 0, 32'h0, 0, 2'b00, 0, '0);
        step(1, 0, 32'h500, 32'h0, 1, 0, 32'h200, 0, 2'b01, 1, 32'h104);
        step(0, 0, 32'h0, 32'h0, 1, 1, 32'h600, 0, 2'b00, 0, '0);
        // predicted taken, actually taken to a different target
        step(1, 1, 32'h104, 32'h200, 0, 0, 32'h0, 0, 2'b00, 0, '0);
        step(0, 0, 32'h0, 32'h0, 1, 1, 32'h240, 0, 2'b01, 1, 32'h240);
        idle();
        // branch held in ID by a 3-cycle stall, then resolved correctly
        step(1, 1, 32'h104, 32'h200, 0, 0, 32'h0, 0, 2'b00, 0, '0);
        for (int i = 0; i < 3; i++)
            step(1, 0, 32'h700, 32'h0, 1, 1, 32'h200, 1, 2'b00, 0, '0);
        step(0, 0, 32'h0, 32'h0, 1, 1, 32'h200, 0, 2'b10, 0, '0);
        idle();
`ifdef BR_STATS_EN
        chk("br_count_5", br_count, 5);
        chk("miss_count_2", miss_count, 2);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 0, 2'b00, 0, '0);
            step(0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 0, 2'b01, 1, 32'h20);
        end
        idle();
        chk("br_count_sat", br_count, 7);
        chk("miss_count_sat", miss_count, 7);
`else
        chk("br_count_absent", br_count, 0);
        chk("miss_count_absent", miss_count, 0);
`endif
        repeat (2) idle();
        chk("pulse_queue_drained", pq.size(), 0);
        chk("redirect_queue_drained", rq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
